cpu_clk_ctrl: RTL and testbench

//   Run/step controller that sits directly downstream of clk_div. Synchronises
//   the divided slow clock into the clk_in domain and turns it into single-cycle
//   CPU clock-enable pulses (cpu_ce). Modes: free-run, single-step from a

---
 rtl/cpu_clk_ctrl_pkg.sv | 12 +
 rtl/cpu_clk_ctrl_btn_debounce.sv | 53 +++++
 rtl/cpu_clk_ctrl.sv | 107 ++++++++++
 tb/tb_cpu_clk_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared definitions for the CPU run/step clock controller and its consumers
// (e.g. the display decoder that renders the state field).
package cpu_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } cpu_state_t;

endpackage

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a
// one-cycle press pulse on each debounced 0->1 transition.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned DB_WIDTH        = 20
) (
  input  logic clk_in,
  input  logic rst,
  input  logic en,
  input  logic btn,
  output logic press
);

  localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                sync1;
  logic                sync2;
  logic                stable;
  logic [DB_WIDTH-1:0] cnt;

  // Synchroniser runs regardless of en so the level is always fresh.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Stability counter; the stable level flips only after a full quiet window.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt    <= '0;
      stable <= 1'b0;
      press  <= 1'b0;
    end else if (!en) begin
      press  <= 1'b0;
    end else if (sync2 == stable) begin
      cnt    <= '0;
      press  <= 1'b0;
    end else if (cnt == DB_LAST) begin
      cnt    <= '0;
      stable <= sync2;
      press  <= sync2;
    end else begin
      cnt    <= cnt + 1'b1;
      press  <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Run/step controller: turns the asynchronous divided clock into single-cycle
// CPU clock-enable pulses, with free-run, single-step and halt modes, and
// counts the pulses issued.
module cpu_clk_ctrl
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned DB_WIDTH        = 20,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 slow_clk,
  input  logic                 mode_run,
  input  logic                 btn_step,
  input  logic                 halt,
  output logic                 cpu_ce,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] cycle_cnt
);

  cpu_state_t st;
  logic       s1;
  logic       s2;
  logic       s3;
  logic       tick;
  logic       press;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_WIDTH       (DB_WIDTH)
  ) u_btn_debounce (
    .clk_in(clk_in),
    .rst   (rst),
    .en    (en),
    .btn   (btn_step),
    .press (press)
  );

  // Slow-clock synchroniser plus delay flop for rising-edge detection.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= slow_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick  = s2 & ~s3;
  assign state = st;

  // Mode FSM with registered enable pulse and retired-cycle counter.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      st        <= ST_IDLE;
      cpu_ce    <= 1'b0;
      cycle_cnt <= '0;
    end else if (!en) begin
      cpu_ce <= 1'b0;
    end else begin
      cpu_ce <= 1'b0;
      unique case (st)
        ST_IDLE: begin
          if (mode_run) begin
            st <= ST_RUN;
          end else if (press) begin
            st <= ST_STEP;
          end
        end
        ST_RUN: begin
          if (halt) begin
            st <= ST_HALT;
          end else begin
            cpu_ce <= tick;
            if (tick) begin
              cycle_cnt <= cycle_cnt + 1'b1;
            end
            if (!mode_run) begin
              st <= ST_IDLE;
            end
          end
        end
        ST_STEP: begin
          if (halt) begin
            st <= ST_HALT;
          end else if (tick) begin
            cpu_ce    <= 1'b1;
            cycle_cnt <= cycle_cnt + 1'b1;
            st        <= ST_IDLE;
          end
        end
        ST_HALT: begin
          if (!halt && !mode_run) begin
            st <= ST_IDLE;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl with short debounce and narrow counter.
module tb_cpu_clk_ctrl;

  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic       slow_clk = 1'b0;
  logic       mode_run = 1'b0;
  logic       btn_step = 1'b0;
  logic       halt = 1'b0;
  logic       cpu_ce;
  logic [1:0] state;
  logic [3:0] cycle_cnt;

  int n_cmp = 0;
  int n_mis = 0;
  int ce_count = 0;
  int consec = 0;
  logic prev_ce = 1'b0;
  int base;

  cpu_clk_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .DB_WIDTH       (3),
    .CNT_WIDTH      (4)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .en       (en),
    .slow_clk (slow_clk),
    .mode_run (mode_run),
    .btn_step (btn_step),
    .halt     (halt),
    .cpu_ce   (cpu_ce),
    .state    (state),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (cpu_ce === 1'b1) begin
      ce_count = ce_count + 1;
      if (prev_ce === 1'b1) consec = consec + 1;
    end
    prev_ce = cpu_ce;
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic run_periods(input int n);
    for (int i = 0; i < n; i++) begin
      slow_clk = 1'b1;
      repeat (5) cyc();
      slow_clk = 1'b0;
      repeat (5) cyc();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mode_run = 1'b1;
    cyc();
    rst = 1'b0;
    n_cmp++; if (state !== 2'd0) begin n_mis++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_cmp++; if (cpu_ce !== 1'b0) begin n_mis++; $display("FAIL reset_ce: got %0b expected 0", cpu_ce); end
    n_cmp++; if (cycle_cnt !== 4'd0) begin n_mis++; $display("FAIL reset_cnt: got %0d expected 0", cycle_cnt); end
  endtask

  task automatic test_run();
    base = ce_count;
    cyc();
    n_cmp++; if (state !== 2'd1) begin n_mis++; $display("FAIL run_enter: got %0d expected 1", state); end
    slow_clk = 1'b1;
    cyc();  // edge k: first sample high
    n_cmp++; if (cpu_ce !== 1'b0) begin n_mis++; $display("FAIL run_lat_k: got %0b expected 0", cpu_ce); end
    cyc();  // k+1: tick true
    n_cmp++; if (cpu_ce !== 1'b0) begin n_mis++; $display("FAIL run_lat_k1: got %0b expected 0", cpu_ce); end
    cyc();  // k+2: pulse registered
    n_cmp++; if (cpu_ce !== 1'b1) begin n_mis++; $display("FAIL run_lat_k2: got %0b expected 1", cpu_ce); end
    cyc();
    n_cmp++; if (cpu_ce !== 1'b0) begin n_mis++; $display("FAIL run_width: got %0b expected 0", cpu_ce); end
    cyc();
    slow_clk = 1'b0;
    repeat (5) cyc();
    run_periods(4);
    n_cmp++; if (ce_count - base !== 5) begin n_mis++; $display("FAIL run_pulses: got %0d expected 5", ce_count - base); end
    n_cmp++; if (cycle_cnt !== 4'd5) begin n_mis++; $display("FAIL run_cnt: got %0d expected 5", cycle_cnt); end
  endtask

  task automatic test_step();
    mode_run = 1'b0;
    cyc();
    n_cmp++; if (state !== 2'd0) begin n_mis++; $display("FAIL step_idle: got %0d expected 0", state); end
    base = ce_count;
    btn_step = 1'b1;
    repeat (2) cyc();
    btn_step = 1'b0;
    repeat (10) cyc();
    n_cmp++; if (state !== 2'd0) begin n_mis++; $display("FAIL step_glitch_state: got %0d expected 0", state); end
    btn_step = 1'b1;
    repeat (8) cyc();
    btn_step = 1'b0;
    n_cmp++; if (state !== 2'd2) begin n_mis++; $display("FAIL step_enter: got %0d expected 2", state); end
    repeat (10) cyc();
    n_cmp++; if (state !== 2'd2) begin n_mis++; $display("FAIL step_wait: got %0d expected 2", state); end
    n_cmp++; if (ce_count - base !== 0) begin n_mis++; $display("FAIL step_no_early_ce: got %0d expected 0", ce_count - base); end
    run_periods(1);
    n_cmp++; if (ce_count - base !== 1) begin n_mis++; $display("FAIL step_pulse: got %0d expected 1", ce_count - base); end
    n_cmp++; if (state !== 2'd0) begin n_mis++; $display("FAIL step_back_idle: got %0d expected 0", state); end
    n_cmp++; if (cycle_cnt !== 4'd6) begin n_mis++; $display("FAIL step_cnt: got %0d expected 6", cycle_cnt); end
  endtask

  task automatic test_halt();
    base = ce_count;
    mode_run = 1'b1;
    cyc();
    slow_clk = 1'b1;
    cyc();  // k
    cyc();  // k+1: tick true now
    halt = 1'b1;
    cyc();
    n_cmp++; if (state !== 2'd3) begin n_mis++; $display("FAIL halt_enter: got %0d expected 3", state); end
    n_cmp++; if (cpu_ce !== 1'b0) begin n_mis++; $display("FAIL halt_ce: got %0b expected 0", cpu_ce); end
    repeat (3) cyc();
    halt = 1'b0;
    repeat (3) cyc();
    n_cmp++; if (state !== 2'd3) begin n_mis++; $display("FAIL halt_hold: got %0d expected 3", state); end
    mode_run = 1'b0;
    cyc();
    n_cmp++; if (state !== 2'd0) begin n_mis++; $display("FAIL halt_exit: got %0d expected 0", state); end
    slow_clk = 1'b0;
    repeat (5) cyc();
    n_cmp++; if (ce_count - base !== 0) begin n_mis++; $display("FAIL halt_pulses: got %0d expected 0", ce_count - base); end
  endtask

  task automatic test_wrap_and_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    mode_run = 1'b1;
    cyc();
    run_periods(17);
    n_cmp++; if (cycle_cnt !== 4'd1) begin n_mis++; $display("FAIL wrap_cnt: got %0d expected 1", cycle_cnt); end
    mode_run = 1'b0;
    cyc();
    btn_step = 1'b1;
    repeat (8) cyc();
    btn_step = 1'b0;
    repeat (6) cyc();
    n_cmp++; if (state !== 2'd2) begin n_mis++; $display("FAIL rst_pre_step: got %0d expected 2", state); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_cmp++; if (state !== 2'd0) begin n_mis++; $display("FAIL rst_step_state: got %0d expected 0", state); end
    n_cmp++; if (cycle_cnt !== 4'd0) begin n_mis++; $display("FAIL rst_step_cnt: got %0d expected 0", cycle_cnt); end
    base = ce_count;
    run_periods(1);
    n_cmp++; if (ce_count - base !== 0) begin n_mis++; $display("FAIL rst_step_lost: got %0d expected 0", ce_count - base); end
  endtask

  task automatic test_enable();
    mode_run = 1'b1;
    cyc();
    base = ce_count;
    run_periods(1);
    n_cmp++; if (cycle_cnt !== 4'd1) begin n_mis++; $display("FAIL en_pre_cnt: got %0d expected 1", cycle_cnt); end
    en = 1'b0;
    mode_run = 1'b0;
    run_periods(2);
    n_cmp++; if (ce_count - base !== 1) begin n_mis++; $display("FAIL en_off_pulses: got %0d expected 1", ce_count - base); end
    n_cmp++; if (cycle_cnt !== 4'd1) begin n_mis++; $display("FAIL en_off_cnt: got %0d expected 1", cycle_cnt); end
    n_cmp++; if (state !== 2'd1) begin n_mis++; $display("FAIL en_off_state: got %0d expected 1", state); end
    mode_run = 1'b1;
    en = 1'b1;
    repeat (3) cyc();
    n_cmp++; if (ce_count - base !== 1) begin n_mis++; $display("FAIL en_no_queue: got %0d expected 1", ce_count - base); end
    run_periods(1);
    n_cmp++; if (ce_count - base !== 2) begin n_mis++; $display("FAIL en_resume: got %0d expected 2", ce_count - base); end
    n_cmp++; if (cycle_cnt !== 4'd2) begin n_mis++; $display("FAIL en_resume_cnt: got %0d expected 2", cycle_cnt); end
  endtask

  initial begin
    repeat (2) cyc();
    test_reset();
    test_run();
    test_step();
    test_halt();
    test_wrap_and_reset();
    test_enable();
    n_cmp++; if (consec !== 0) begin n_mis++; $display("FAIL ce_back_to_back: got %0d expected 0", consec); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
